// File: rtl/sram_song_loader.sv
// Song SRAM writer: assembles big-endian byte pairs from the host receiver into 16-bit words
// and writes them to consecutive SRAM addresses starting at 0. The processor stays paused
// while LOADING is high.
//
// Ports:
//   CLK, RST_N            clock, asynchronous active-low reset
//   START                 pulse: restart at address 0, clear count and flags
//   RX_VALID, RX_DATA     byte strobe and data
//   SRAM_WE/CE/OE/LB/UB   active-low SRAM controls
//   SRAM_A, SRAM_D_OUT    write address and data
//   SRAM_D_OE             1 = drive the SRAM data bus
//   LOADING, BUSY         load in progress / write cycle in progress
//   DONE, ERR_OVERRUN,
//   ERR_FULL              sticky status flags
//   WORD_COUNT            number of words written
module sram_song_loader #(
    parameter int unsigned ADDR_W    = 18,
    parameter int unsigned WE_CYCLES = 2,
    parameter int unsigned MAX_WORDS = 262144
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              START,
    input  logic              RX_VALID,
    input  logic [7:0]        RX_DATA,
    output logic              SRAM_WE,
    output logic              SRAM_CE,
    output logic              SRAM_OE,
    output logic              SRAM_LB,
    output logic              SRAM_UB,
    output logic [ADDR_W-1:0] SRAM_A,
    output logic [15:0]       SRAM_D_OUT,
    output logic              SRAM_D_OE,
    output logic              LOADING,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERR_OVERRUN,
    output logic              ERR_FULL,
    output logic [ADDR_W:0]   WORD_COUNT
);

    localparam int unsigned CntW = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;
    localparam logic [CntW-1:0]   LastCnt  = CntW'(WE_CYCLES - 1);
    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(MAX_WORDS - 1);

    typedef enum logic [2:0] {
        StIdle, StWaitHi, StWaitLo, StWrSetup, StWrPulse, StWrHold, StFinished
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          hi_q, hi_d;
    logic [15:0]         data_q, data_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [ADDR_W:0]     wc_q, wc_d;
    logic                done_q, done_d;
    logic                overrun_q, overrun_d;
    logic                full_q, full_d;
    logic                busy;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            hi_q      <= '0;
            data_q    <= '0;
            cnt_q     <= '0;
            wc_q      <= '0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            full_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            hi_q      <= hi_d;
            data_q    <= data_d;
            cnt_q     <= cnt_d;
            wc_q      <= wc_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
            full_q    <= full_d;
        end
    end

    assign busy = (state_q == StWrSetup) || (state_q == StWrPulse) || (state_q == StWrHold);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        hi_d      = hi_q;
        data_d    = data_q;
        cnt_d     = cnt_q;
        wc_d      = wc_q;
        done_d    = done_q;
        overrun_d = overrun_q;
        full_d    = full_q;
        if (START) begin
            // START wins over everything, including a byte in the same cycle.
            state_d   = StWaitHi;
            addr_d    = '0;
            cnt_d     = '0;
            wc_d      = '0;
            done_d    = 1'b0;
            overrun_d = 1'b0;
            full_d    = 1'b0;
        end else begin
            if (busy && RX_VALID) begin
                overrun_d = 1'b1;
            end
            unique case (state_q)
                StIdle: ;
                StWaitHi: begin
                    if (RX_VALID) begin
                        hi_d    = RX_DATA;
                        state_d = StWaitLo;
                    end
                end
                StWaitLo: begin
                    if (RX_VALID) begin
                        data_d  = {hi_q, RX_DATA};
                        cnt_d   = '0;
                        state_d = StWrSetup;
                    end
                end
                StWrSetup: state_d = StWrPulse;
                StWrPulse: begin
                    if (cnt_q == LastCnt) begin
                        state_d = StWrHold;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StWrHold: begin
                    wc_d = wc_q + 1'b1;
                    if (data_q[15:12] == 4'b0000) begin
                        state_d = StFinished;
                        done_d  = 1'b1;
                    end else if (addr_q == LastAddr) begin
                        // No wrap-around: the song would overwrite its own start.
                        state_d = StFinished;
                        full_d  = 1'b1;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = StWaitHi;
                    end
                end
                StFinished: ;
                default: state_d = StIdle;
            endcase
        end
    end

    // WE decoded straight from state so an async reset releases it immediately.
    assign SRAM_WE     = (state_q != StWrPulse);
    assign SRAM_CE     = 1'b0;
    assign SRAM_LB     = 1'b0;
    assign SRAM_UB     = 1'b0;
    assign LOADING     = (state_q != StIdle) && (state_q != StFinished);
    assign SRAM_OE     = LOADING;
    assign SRAM_D_OE   = busy;
    assign BUSY        = busy;
    assign SRAM_A      = addr_q;
    assign SRAM_D_OUT  = data_q;
    assign DONE        = done_q;
    assign ERR_OVERRUN = overrun_q;
    assign ERR_FULL    = full_q;
    assign WORD_COUNT  = wc_q;

endmodule

// File: tb/tb_sram_song_loader.sv
// Bench for sram_song_loader: directed byte streams, expected SRAM writes queued as stimulus is
// issued and checked by a monitor that watches SRAM_WE / SRAM_D_OE on two instances
// (default capacity and a 4-word capacity).
module tb_sram_song_loader;

    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    logic start = 1'b0, start_s = 1'b0;
    logic rx_valid = 1'b0, rx_valid_s = 1'b0;
    logic [7:0] rx_data = 8'h00;

    always #10 CLK = ~CLK;

    logic we, ce, oe, lb, ub, doe, loading, busy, done, ovr, full;
    logic [17:0] a;
    logic [15:0] d;
    logic [18:0] wc;
    logic s_we, s_ce, s_oe, s_lb, s_ub, s_doe, s_loading, s_busy, s_done, s_ovr, s_full;
    logic [17:0] s_a;
    logic [15:0] s_d;
    logic [18:0] s_wc;

    sram_song_loader dut (
        .CLK(CLK), .RST_N(RST_N), .START(start), .RX_VALID(rx_valid), .RX_DATA(rx_data),
        .SRAM_WE(we), .SRAM_CE(ce), .SRAM_OE(oe), .SRAM_LB(lb), .SRAM_UB(ub),
        .SRAM_A(a), .SRAM_D_OUT(d), .SRAM_D_OE(doe), .LOADING(loading), .BUSY(busy),
        .DONE(done), .ERR_OVERRUN(ovr), .ERR_FULL(full), .WORD_COUNT(wc)
    );

    sram_song_loader #(.MAX_WORDS(4)) dut_s (
        .CLK(CLK), .RST_N(RST_N), .START(start_s), .RX_VALID(rx_valid_s), .RX_DATA(rx_data),
        .SRAM_WE(s_we), .SRAM_CE(s_ce), .SRAM_OE(s_oe), .SRAM_LB(s_lb), .SRAM_UB(s_ub),
        .SRAM_A(s_a), .SRAM_D_OUT(s_d), .SRAM_D_OE(s_doe), .LOADING(s_loading), .BUSY(s_busy),
        .DONE(s_done), .ERR_OVERRUN(s_ovr), .ERR_FULL(s_full), .WORD_COUNT(s_wc)
    );

    typedef struct packed {
        logic        id;
        logic [17:0] addr;
        logic [15:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  n_vec = 0;
    int  n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_wr(input logic id, input logic [17:0] addr, input logic [15:0] data);
        wr_t e;
        e.id = id; e.addr = addr; e.data = data;
        exp_q.push_back(e);
    endtask

    // Monitor: per-instance tracking of write cycles.
    logic        prev_we [2] = '{1'b1, 1'b1};
    logic        prev_doe[2] = '{1'b0, 1'b0};
    int          we_low  [2] = '{0, 0};
    logic [17:0] lat_a   [2];
    logic [15:0] lat_d   [2];

    task automatic mon_step(input int id, input logic w, input logic oe_d,
                            input logic [17:0] ad, input logic [15:0] da);
        wr_t e;
        if (oe_d && !prev_doe[id]) begin
            lat_a[id] = ad;
            lat_d[id] = da;
        end else if (oe_d) begin
            chk("addr_stable", 32'(ad), 32'(lat_a[id]));
            chk("data_stable", 32'(da), 32'(lat_d[id]));
        end
        if (!w && prev_we[id]) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_write: inst %0d addr %0h data %0h, expected no write",
                         id, ad, da);
            end else begin
                e = exp_q.pop_front();
                chk("write_inst", 32'(id), 32'(e.id));
                chk("write_addr", 32'(ad), 32'(e.addr));
                chk("write_data", 32'(da), 32'(e.data));
            end
        end
        if (!w) begin
            we_low[id]++;
        end else begin
            // Only completed writes (still in HOLD with bus driven) get a pulse-width check.
            if (!prev_we[id] && oe_d) chk("we_low_cycles", 32'(we_low[id]), 32'd2);
            we_low[id] = 0;
        end
        prev_we[id]  = w;
        prev_doe[id] = oe_d;
    endtask

    always @(negedge CLK) begin
        mon_step(0, we, doe, a, d);
        mon_step(1, s_we, s_doe, s_a, s_d);
    end

    // Drivers: called at a negedge, return at the next negedge.
    task automatic send(input logic sel, input logic [7:0] b);
        rx_data = b;
        if (sel) rx_valid_s = 1'b1;
        else     rx_valid = 1'b1;
        @(negedge CLK);
        rx_valid   = 1'b0;
        rx_valid_s = 1'b0;
    endtask

    task automatic pair(input logic sel, input logic [7:0] hi, input logic [7:0] lo);
        send(sel, hi);
        send(sel, lo);
        repeat (5) @(negedge CLK);
    endtask

    task automatic pulse_start(input logic sel);
        if (sel) start_s = 1'b1;
        else     start = 1'b1;
        @(negedge CLK);
        start   = 1'b0;
        start_s = 1'b0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        repeat (2) @(negedge CLK);
        chk("rst_we", 32'(we), 32'd1);
        chk("rst_oe", 32'(oe), 32'd0);
        chk("rst_ce_lb_ub", 32'({ce, lb, ub}), 32'd0);
        chk("rst_doe", 32'(doe), 32'd0);
        chk("rst_loading_busy", 32'({loading, busy}), 32'd0);
        chk("rst_flags", 32'({done, ovr, full}), 32'd0);
        chk("rst_wc", 32'(wc), 32'd0);
        chk("rst_addr", 32'(a), 32'd0);
        RST_N = 1'b1;
        @(negedge CLK);

        // IDLE ignores bytes
        pair(0, 8'h8A, 8'h25);
        chk("idle_wc", 32'(wc), 32'd0);
        chk("idle_loading", 32'(loading), 32'd0);

        // Single write with timing
        pulse_start(0);
        chk("load_oe", 32'(oe), 32'd1);
        chk("load_loading", 32'(loading), 32'd1);
        expect_wr(0, 18'd0, 16'h8A25);
        send(0, 8'h8A);
        send(0, 8'h25);
        chk("setup_we", 32'(we), 32'd1);
        chk("setup_doe", 32'(doe), 32'd1);
        chk("setup_busy", 32'(busy), 32'd1);
        chk("setup_ad", 32'({a[15:0], d}), 32'h0000_8A25);
        repeat (4) @(negedge CLK);
        chk("w1_busy_doe", 32'({busy, doe}), 32'd0);
        chk("w1_loading", 32'(loading), 32'd1);
        chk("w1_wc", 32'(wc), 32'd1);
        chk("w1_next_addr", 32'(a), 32'd1);

        // START mid-pair drops the high byte
        pulse_start(0);
        send(0, 8'h8A);
        pulse_start(0);
        expect_wr(0, 18'd0, 16'h3344);
        pair(0, 8'h33, 8'h44);
        chk("midpair_wc", 32'(wc), 32'd1);

        // Overrun
        pulse_start(0);
        expect_wr(0, 18'd0, 16'h1160);
        expect_wr(0, 18'd1, 16'h8A25);
        send(0, 8'h11);
        send(0, 8'h60);
        send(0, 8'h99);
        repeat (4) @(negedge CLK);
        chk("ovr_flag", 32'(ovr), 32'd1);
        pair(0, 8'h8A, 8'h25);
        chk("ovr_wc", 32'(wc), 32'd2);

        // Three words ending in an end word
        pulse_start(0);
        chk("start_clears_ovr", 32'(ovr), 32'd0);
        expect_wr(0, 18'd0, 16'h1160);
        expect_wr(0, 18'd1, 16'h8A25);
        expect_wr(0, 18'd2, 16'h0000);
        pair(0, 8'h11, 8'h60);
        pair(0, 8'h8A, 8'h25);
        pair(0, 8'h00, 8'h00);
        chk("end_done", 32'(done), 32'd1);
        chk("end_loading", 32'(loading), 32'd0);
        chk("end_oe", 32'(oe), 32'd0);
        chk("end_wc", 32'(wc), 32'd3);
        chk("end_full", 32'(full), 32'd0);
        pair(0, 8'h12, 8'h34);
        chk("finished_wc", 32'(wc), 32'd3);

        // START mid-write, with a byte in the same cycle
        pulse_start(0);
        expect_wr(0, 18'd0, 16'h5566);
        send(0, 8'h55);
        send(0, 8'h66);
        @(negedge CLK);
        chk("mid_we_low", 32'(we), 32'd0);
        start = 1'b1;
        rx_valid = 1'b1;
        rx_data = 8'hEE;
        @(negedge CLK);
        start = 1'b0;
        rx_valid = 1'b0;
        chk("abort_we", 32'(we), 32'd1);
        chk("abort_doe", 32'(doe), 32'd0);
        chk("abort_wc_addr", 32'({wc, a[0]}), 32'd0);
        chk("abort_flags", 32'({done, ovr, full}), 32'd0);
        chk("abort_loading", 32'(loading), 32'd1);
        expect_wr(0, 18'd0, 16'h7788);
        pair(0, 8'h77, 8'h88);
        chk("abort_next_wc", 32'(wc), 32'd1);

        // Reset mid-write
        pulse_start(0);
        expect_wr(0, 18'd0, 16'h9ABC);
        send(0, 8'h9A);
        send(0, 8'hBC);
        @(negedge CLK);
        #2 RST_N = 1'b0;
        #1;
        chk("arst_we", 32'(we), 32'd1);
        chk("arst_doe", 32'(doe), 32'd0);
        chk("arst_loading_busy", 32'({loading, busy}), 32'd0);
        chk("arst_flags_wc", 32'({done, ovr, full, wc}), 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        pair(0, 8'h12, 8'h34);
        chk("arst_idle_wc", 32'(wc), 32'd0);
        chk("arst_idle_loading", 32'(loading), 32'd0);

        // Capacity exhaustion on the 4-word instance
        pulse_start(1);
        expect_wr(1, 18'd0, 16'h1001);
        expect_wr(1, 18'd1, 16'h2002);
        expect_wr(1, 18'd2, 16'h3003);
        expect_wr(1, 18'd3, 16'h4004);
        pair(1, 8'h10, 8'h01);
        pair(1, 8'h20, 8'h02);
        pair(1, 8'h30, 8'h03);
        pair(1, 8'h40, 8'h04);
        pair(1, 8'h50, 8'h05);
        chk("full_flag", 32'(s_full), 32'd1);
        chk("full_done", 32'(s_done), 32'd0);
        chk("full_wc", 32'(s_wc), 32'd4);
        chk("full_loading", 32'({s_loading, s_busy, s_ovr}), 32'd0);
        chk("full_const_ctl", 32'({s_ce, s_lb, s_ub, s_oe}), 32'd0);

        repeat (3) @(negedge CLK);
        chk("exp_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
